// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt controller.
// FSM encoding and line-count constants.
package irq_pkg;
  localparam int IRQ_NUM_DEF  = 8;
  localparam int IRQ_ID_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;
endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder for the candidate set.
// Lowest set index wins.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = IRQ_NUM_DEF,
  parameter int ID_W    = IRQ_ID_W_DEF
) (
  input  logic [NUM_IRQ-1:0] req_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

  // Scan high to low so the lowest set index is the last written.
  always_comb begin
    valid_o = |req_i;
    id_o    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt request controller: edge capture, masking,
// priority, request/ack handshake and in-service tracking.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = IRQ_NUM_DEF,
  parameter int ID_W    = IRQ_ID_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               nmi_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               int_ack,
  input  logic               eoi,
  output logic               interrupt_r,
  output logic               non_maskable_interrupt,
  output logic [ID_W-1:0]    irq_id,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending
);

  irq_state_t state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q, irq_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               nmi_q, nmi_d;
  logic               nmi_pend_q, nmi_pend_d;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] clr;
  logic               enc_valid;
  logic [ID_W-1:0]    enc_id;
  logic               nmi_ack;

  assign rise    = irq_in & ~irq_q;
  assign cand    = pend_q & mask_q;
  assign nmi_ack = int_ack & nmi_pend_q;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_enc (
    .req_i   (cand),
    .valid_o (enc_valid),
    .id_o    (enc_id)
  );

  // Maskable request FSM; an NMI ack steals a shared int_ack.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (enc_valid) begin
          id_d    = enc_id;
          state_d = REQ;
        end
      end
      REQ: begin
        if (int_ack && !nmi_ack) begin
          clr[id_q] = 1'b1;
          state_d   = SERVICE;
        end else if (!mask_q[id_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Edge capture, pending/mask update; a new rise beats a clear.
  always_comb begin
    irq_d      = irq_in;
    nmi_d      = nmi_in;
    pend_d     = (pend_q & ~clr) | rise;
    mask_d     = mask_we ? mask_wdata : mask_q;
    nmi_pend_d = (nmi_in & ~nmi_q) | (nmi_pend_q & ~nmi_ack);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      irq_q      <= '0;
      pend_q     <= '0;
      mask_q     <= '0;
      id_q       <= '0;
      nmi_q      <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_q      <= irq_d;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      id_q       <= id_d;
      nmi_q      <= nmi_d;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  assign interrupt_r            = (state_q == REQ);
  assign in_service             = (state_q == SERVICE);
  assign non_maskable_interrupt = nmi_pend_q;
  assign irq_id                 = id_q;
  assign pending                = pend_q;

endmodule
